led_shift_driver: RTL and testbench



---
 rtl/led_shift_driver.sv | 190 +++++++++++++++++++
 tb/tb_led_shift_driver.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_driver.sv
// led_shift_driver: serialises a WIDTH-bit LED vector into a 74HC595-style
// shift/latch chain. A frame goes out after reset, on every change of led_in,
// and on a refresh request seen while idle.
// Optional macro LED_SHIFT_DIMMING_EN adds bright[3:0] and PWM dimming on oe_n.
module led_shift_driver #(
  parameter int WIDTH     = 16,
  parameter int DIV       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] led_in,
  input  logic             refresh,
`ifdef LED_SHIFT_DIMMING_EN
  input  logic [3:0]       bright,
`endif
  output logic             ser,
  output logic             srclk,
  output logic             rclk,
  output logic             oe_n,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = $clog2(DIV + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             ser_q, ser_d;
  logic             srclk_q, srclk_d;
  logic             rclk_q, rclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             latched_q, latched_d;

  logic             start;
  logic [WIDTH-1:0] shifted;
  logic             first_bit;
  logic             next_bit;

  assign start = pending_q | refresh | (led_in != shadow_q);

  // Bit ordering: which end of the vector leaves first and how the register advances
  always_comb begin
    if (MSB_FIRST) begin
      shifted   = {shift_reg_q[WIDTH-2:0], 1'b0};
      next_bit  = shift_reg_q[WIDTH-2];
      first_bit = led_in[WIDTH-1];
    end else begin
      shifted   = {1'b0, shift_reg_q[WIDTH-1:1]};
      next_bit  = shift_reg_q[1];
      first_bit = led_in[0];
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    ser_d       = ser_q;
    srclk_d     = srclk_q;
    rclk_d      = rclk_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    latched_d   = latched_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_reg_d = led_in;
          shadow_d    = led_in;
          pending_d   = 1'b0;
          bit_cnt_d   = '0;
          div_cnt_d   = '0;
          ser_d       = first_bit;
          srclk_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!srclk_q) begin
            srclk_d = 1'b1;
          end else begin
            srclk_d     = 1'b0;
            shift_reg_d = shifted;
            bit_cnt_d   = bit_cnt_q + CNT_W'(1);
            ser_d       = next_bit;
            if (bit_cnt_q == BIT_LAST) begin
              ser_d   = 1'b0;
              rclk_d  = 1'b1;
              state_d = LATCH;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          rclk_d    = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          latched_d = 1'b1;
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame without latching
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_reg_q <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b1;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      ser_q       <= 1'b0;
      srclk_q     <= 1'b0;
      rclk_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      latched_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      ser_q       <= ser_d;
      srclk_q     <= srclk_d;
      rclk_q      <= rclk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      latched_q   <= latched_d;
    end
  end

  assign ser   = ser_q;
  assign srclk = srclk_q;
  assign rclk  = rclk_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef LED_SHIFT_DIMMING_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + 4'd1;

  // Free-running PWM phase counter for brightness control
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign oe_n = ~latched_q | (pwm_cnt_q >= bright);
`else
  assign oe_n = ~latched_q;
`endif

endmodule

// File: tb/tb_led_shift_driver.sv
// tb_led_shift_driver: scoreboard bench for led_shift_driver. Two instances:
// u_dut0 with DIV=2/MSB first, u_dut1 with DIV=1/LSB first.
module tb_led_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst1 = 1'b1;
  logic        refresh0 = 1'b0;
  logic        refresh1 = 1'b0;
  logic [15:0] led0 = 16'h0000, led1 = 16'h8003;
  logic        ser0, srclk0, rclk0, oe_n0, busy0, done0;
  logic        ser1, srclk1, rclk1, oe_n1, busy1, done1;
`ifdef LED_SHIFT_DIMMING_EN
  logic [3:0]  bright0 = 4'd15, bright1 = 4'd15;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          cyc[2], nbits[2], rhigh[2], start_cyc[2], frames[2];
  logic [15:0] frame[2];
  logic        prev_sr[2], prev_rc[2], prev_busy[2], prev_done[2];

  led_shift_driver #(.WIDTH(16), .DIV(2), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst0), .led_in(led0), .refresh(refresh0),
`ifdef LED_SHIFT_DIMMING_EN
    .bright(bright0),
`endif
    .ser(ser0), .srclk(srclk0), .rclk(rclk0), .oe_n(oe_n0), .busy(busy0), .done(done0)
  );

  led_shift_driver #(.WIDTH(16), .DIV(1), .MSB_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst1), .led_in(led1), .refresh(refresh1),
`ifdef LED_SHIFT_DIMMING_EN
    .bright(bright1),
`endif
    .ser(ser1), .srclk(srclk1), .rclk(rclk1), .oe_n(oe_n1), .busy(busy1), .done(done1)
  );

  // Compare one observed value against its expectation and log mismatches
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [5:0] outs0();
    return {ser0, srclk0, rclk0, oe_n0, busy0, done0};
  endfunction

  function automatic logic [5:0] outs1();
    return {ser1, srclk1, rclk1, oe_n1, busy1, done1};
  endfunction

  // Reassemble frames from the chain pins and score them against the queue
  task automatic monitorSample(input int idx, input logic r, input logic s, input logic sc,
                               input logic rc, input logic b, input logic d,
                               input int div_v, input bit msb);
    logic [15:0] e;
    cyc[idx]++;
    if (r) begin
      nbits[idx] = 0; frame[idx] = '0; rhigh[idx] = 0; start_cyc[idx] = -1;
      prev_sr[idx] = 1'b0; prev_rc[idx] = 1'b0; prev_busy[idx] = 1'b0; prev_done[idx] = 1'b0;
    end else begin
      if (b && !prev_busy[idx]) start_cyc[idx] = cyc[idx] - 1;
      if (sc && !prev_sr[idx]) begin
        nbits[idx]++;
        frame[idx] = msb ? {frame[idx][14:0], s} : {s, frame[idx][15:1]};
      end
      if (rc) rhigh[idx]++;
      if (!rc && prev_rc[idx]) begin
        checkOutput("rclk_width", rhigh[idx], div_v);
        rhigh[idx] = 0;
      end
      if (rc && !prev_rc[idx]) begin
        checkOutput("bit_count", nbits[idx], 16);
        if (idx == 0 && exp_q0.size() > 0) begin
          e = exp_q0.pop_front();
          checkOutput("frame_data0", frame[idx], e);
        end else if (idx == 1 && exp_q1.size() > 0) begin
          e = exp_q1.pop_front();
          checkOutput("frame_data1", frame[idx], e);
        end else begin
          checkOutput("unexpected_frame", frame[idx], 32'hDEAD_BEEF);
        end
      end
      if (d) begin
        checkOutput("done_pulse_width", prev_done[idx], 0);
        checkOutput("done_latency", cyc[idx] - start_cyc[idx], 2 * div_v * 16 + div_v + 1);
        frames[idx]++;
        nbits[idx] = 0;
      end
      prev_sr[idx] = sc; prev_rc[idx] = rc; prev_busy[idx] = b; prev_done[idx] = d;
    end
  endtask

  // Sample both chains half a cycle away from the active edge
  always @(negedge clk) begin
    monitorSample(0, rst0, ser0, srclk0, rclk0, busy0, done0, 2, 1'b1);
    monitorSample(1, rst1, ser1, srclk1, rclk1, busy1, done1, 1, 1'b0);
  end

  task automatic applyStimulus(input int idx, input logic [15:0] v, input bit expect_frame);
    @(negedge clk);
    if (idx == 0) led0 = v; else led1 = v;
    if (expect_frame) begin
      if (idx == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
    end
  endtask

  task automatic pulseRefresh();
    @(negedge clk); refresh0 = 1'b1;
    @(negedge clk); refresh0 = 1'b0;
  endtask

  task automatic waitFrames(input int idx, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (frames[idx] >= target) break;
    end
    checkOutput("frame_count", frames[idx], target);
  endtask

  task automatic waitBusy(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (busy0) break;
    end
    checkOutput("busy_seen", busy0, 1);
  endtask

  // Main stimulus sequence
  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs0", outs0(), 6'b000100);
    checkOutput("reset_outputs1", outs1(), 6'b000100);

    exp_q0.push_back(16'h0000);
    rst0 = 1'b0;
    waitFrames(0, 1, 300);
    @(negedge clk);
`ifndef LED_SHIFT_DIMMING_EN
    checkOutput("oe_n_after_latch", oe_n0, 0);
`endif
    checkOutput("busy_after_frame", busy0, 0);
    repeat (20) @(negedge clk);
    checkOutput("idle_no_frame", frames[0], 1);

    applyStimulus(0, 16'h8001, 1);
    waitFrames(0, 2, 300);
    repeat (3) @(negedge clk);
    applyStimulus(0, 16'h8003, 1);
    waitFrames(0, 3, 300);
    repeat (3) @(negedge clk);

    applyStimulus(0, 16'h001F, 1);
    waitBusy(20);
    repeat (10) @(negedge clk);
    applyStimulus(0, 16'h00FF, 0);
    repeat (10) @(negedge clk);
    applyStimulus(0, 16'h07FF, 1);
    waitFrames(0, 5, 400);
    repeat (100) @(negedge clk);
    checkOutput("no_extra_after_change", frames[0], 5);

    applyStimulus(0, 16'hFFFF, 1);
    waitFrames(0, 6, 300);
    repeat (3) @(negedge clk);
    exp_q0.push_back(16'hFFFF);
    pulseRefresh();
    waitFrames(0, 7, 300);
    repeat (3) @(negedge clk);
    exp_q0.push_back(16'hFFFF);
    pulseRefresh();
    waitBusy(20);
    repeat (20) @(negedge clk);
    pulseRefresh();
    waitFrames(0, 8, 300);
    repeat (100) @(negedge clk);
    checkOutput("refresh_busy_ignored", frames[0], 8);

    applyStimulus(0, 16'h1234, 0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (nbits[0] >= 7) break;
    end
    checkOutput("reached_bit7", nbits[0], 7);
    @(negedge clk); rst0 = 1'b1;
    @(negedge clk);
    checkOutput("midframe_reset_outputs", outs0(), 6'b000100);
    checkOutput("no_latch_on_abort", frames[0], 8);
    exp_q0.push_back(16'h1234);
    rst0 = 1'b0;
    waitFrames(0, 9, 300);

    exp_q1.push_back(16'h8003);
    @(negedge clk); rst1 = 1'b0;
    waitFrames(1, 1, 200);
    repeat (3) @(negedge clk);
    applyStimulus(1, 16'h8001, 1);
    waitFrames(1, 2, 200);
    @(negedge clk);
`ifndef LED_SHIFT_DIMMING_EN
    checkOutput("oe_n_after_latch1", oe_n1, 0);
`else
    begin
      int low_cnt;
      low_cnt = 0;
      bright0 = 4'd4;
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (!oe_n0) low_cnt++;
      end
      checkOutput("pwm_low_cycles", low_cnt, 4);
    end
`endif

    checkOutput("queue0_empty", exp_q0.size(), 0);
    checkOutput("queue1_empty", exp_q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
